debug_dump: RTL and testbench
=============================

DEBUG_DUMP -- requirements
Module: debug_dump

Interface
REQ-001 Parameter NUM_REGS, default 32, number of 32-bit register-file words in the snapshot.
REQ-002 Parameter NUM_MEM, default 10, number of 32-bit data-memory words in the snapshot.
REQ-003 Parameter PC_W, default 10, program-counter width.
REQ-004 Parameter DATA_W, fixed at 32, word width; other values are out of scope.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cmd_data  in  8  command byte from the host link.
REQ-008 cmd_valid  in  1  cmd_data valid.
REQ-009 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-010 pipe_enable  out  1  pipeline clock-enable; pipeline advances one cycle per high cycle.
REQ-011 pc  in  PC_W  current PC of the pipeline.
REQ-012 regs_flat  in  NUM_REGS*32  flattened register file, word i at bits [32*i+31:32*i].
REQ-013 mem_flat  in  NUM_MEM*32  flattened data memory, same packing.
REQ-014 tx_data  out  8  frame byte to the host link.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 tx_ready  in  1  byte consumed when tx_valid && tx_ready.
REQ-017 halted  out  1  high in IDLE.

Function
REQ-018 States: IDLE, RUN, STEP, CAPTURE, SEND.
REQ-019 Commands: 0x63 'c' run, 0x73 's' step, 0x64 'd' dump, 0x68 'h' halt; all other bytes are consumed and ignored.
REQ-020 cmd_ready is high in IDLE and RUN, low in STEP, CAPTURE, and SEND.
REQ-021 IDLE: 'c' goes to RUN, 's' goes to STEP, 'd' goes to CAPTURE, 'h' stays in IDLE.
REQ-022 RUN: pipe_enable is high every cycle; 'h' drops pipe_enable from the next cycle and enters CAPTURE; 'c', 's', and 'd' are ignored.
REQ-023 STEP: pipe_enable is high for exactly one cycle, then the block enters CAPTURE.
REQ-024 pipe_enable is low in IDLE, CAPTURE, and SEND.
REQ-025 CAPTURE, one cycle: latch pc (zero-extended to 32 bits), cycle_cnt, regs_flat, and mem_flat into a snapshot register; go to SEND.
REQ-026 cycle_cnt is a 32-bit count of pipe_enable-high cycles; it wraps 0xFFFFFFFF to 0 and is not cleared by halt or step.
REQ-027 Frame word order: pc, cycle_cnt, reg[0..NUM_REGS-1], mem[0..NUM_MEM-1]; each word is sent MSB byte first.
REQ-028 Frame length is 4*(2+NUM_REGS+NUM_MEM) bytes (176 at defaults); the byte index counter is sized by $clog2 of that length.
REQ-029 SEND: tx_valid is high; tx_data and tx_valid hold stable while !tx_ready; the index advances only on handshake.
REQ-030 When the final byte is accepted, the block returns to IDLE in the next cycle with tx_valid low.
REQ-031 Frames are taken from the snapshot only; input changes during SEND do not alter the frame.
REQ-032 The first byte of a frame appears one cycle after CAPTURE.
REQ-033 With tx_ready held high, a frame takes one byte per cycle with no bubbles.

Reset
REQ-034 On reset: state IDLE, pipe_enable 0, tx_valid 0, tx_data 0x00, cmd_ready 1, halted 1, cycle_cnt 0, byte index 0, snapshot 0.
REQ-035 Reset mid-frame or mid-run aborts immediately; no partial-frame resumption; the next frame restarts at byte 0.
REQ-036 Reset has priority over a simultaneous command or handshake.

Structure
REQ-037 Package debug_pkg holds command byte constants, the state encoding, and the DATA_W and header-word-count constants.
REQ-038 One sub-module, frame_serializer (snapshot-word-to-byte shifter with valid/ready), is instantiated once; the FSM and counters stay in debug_dump.

Verification
REQ-039 Reset, then 's' with tx_ready=1 -> pipe_enable high exactly 1 cycle; 176 bytes sent; bytes 4..7 = 00 00 00 01; state back to IDLE.
REQ-040 Reset, 'c', wait 100 cycles, 'h' -> cycle_cnt field = 101 (enable cycle count incl. accept); pipe_enable low in the cycle after 'h'.
REQ-041 'd' with regs_flat word 5 = 0xDEADBEEF, tx_ready toggling 1/0 -> bytes 28..31 = DE AD BE EF; tx_data stable during every ready-low cycle.
REQ-042 Reset asserted at byte 50 of a frame -> tx_valid low the next cycle; a following 'd' restarts at byte 0.
REQ-043 Byte 0x41 in IDLE and 's' during RUN -> consumed, no state change; 's' sent during SEND -> cmd_ready low, not accepted.
REQ-044 cycle_cnt preloaded near 0xFFFFFFFE, 's' three times -> frames report FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/debug_dump_pkg.sv
// Shared constants and types for the debug dump block: host command bytes,
// FSM state encoding and frame geometry.
package debug_pkg;

  localparam int DataW    = 32;
  localparam int HdrWords = 2;

  localparam logic [7:0] CmdRun  = 8'h63;
  localparam logic [7:0] CmdStep = 8'h73;
  localparam logic [7:0] CmdDump = 8'h64;
  localparam logic [7:0] CmdHalt = 8'h68;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StCapture,
    StSend
  } state_t;

  function automatic int frame_bytes(input int num_regs, input int num_mem);
    return 4 * (HdrWords + num_regs + num_mem);
  endfunction

endpackage

// File: rtl/debug_dump_if.sv
// Host-link handshake bundle: command bytes in, frame bytes out.
interface debug_dump_if;

  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

endinterface

// File: rtl/debug_dump_frame_serializer.sv
// Turns one snapshot word plus a byte selector into an MSB-first byte stream
// with a valid/ready handshake.
module frame_serializer #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_byte_sel,
  input  logic              i_valid,
  input  logic              i_ready,
  output logic [7:0]        o_data,
  output logic              o_valid,
  output logic              o_fire
);

  logic [DATA_W-1:0] w_shifted;

  always_comb begin
    // Byte 0 of a word is its most significant byte.
    w_shifted = i_word << {i_byte_sel, 3'b000};
    o_valid   = i_valid;
    o_data    = i_valid ? w_shifted[DATA_W-1 -: 8] : 8'h00;
    o_fire    = i_valid && i_ready;
  end

endmodule

// File: rtl/debug_dump.sv
// Debug controller: run/step/halt the pipeline via its clock enable and dump a
// snapshot of pc, cycle count, registers and memory as a byte frame.
module debug_dump
  import debug_pkg::*;
#(
  parameter int          NUM_REGS      = 32,
  parameter int          NUM_MEM       = 10,
  parameter int          PC_W          = 10,
  parameter int          DATA_W        = DataW,
  parameter logic [31:0] CYCLE_CNT_RST = '0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  debug_dump_if.slave                io_bus,
  output logic                       o_pipe_enable,
  input  logic [PC_W-1:0]            i_pc,
  input  logic [NUM_REGS*DATA_W-1:0] i_regs_flat,
  input  logic [NUM_MEM*DATA_W-1:0]  i_mem_flat,
  output logic                       o_halted
);

  localparam int FrameWords = HdrWords + NUM_REGS + NUM_MEM;
  localparam int FrameBytes = frame_bytes(NUM_REGS, NUM_MEM);
  localparam int IdxW       = $clog2(FrameBytes);

  state_t              r_state;
  state_t              w_state_d;
  logic [DATA_W-1:0]   r_cycle_cnt;
  logic [IdxW-1:0]     r_byte_idx;
  logic [DATA_W-1:0]   r_snap    [FrameWords];
  logic [DATA_W-1:0]   w_snap_in [FrameWords];

  logic                w_cmd_ready;
  logic                w_cmd_fire;
  logic                w_pipe_en;
  logic                w_sending;
  logic                w_tx_fire;
  logic                w_last_byte;
  logic [IdxW-3:0]     w_word_idx;
  logic [7:0]          w_tx_data;
  logic                w_tx_valid;

  assign w_cmd_ready = (r_state == StIdle) || (r_state == StRun);
  assign w_cmd_fire  = io_bus.cmd_valid && w_cmd_ready;
  assign w_pipe_en   = (r_state == StRun) || (r_state == StStep);
  assign w_sending   = (r_state == StSend);
  assign w_last_byte = (r_byte_idx == IdxW'(FrameBytes - 1));
  assign w_word_idx  = r_byte_idx[IdxW-1:2];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_cmd_fire) begin
          case (io_bus.cmd_data)
            CmdRun:  w_state_d = StRun;
            CmdStep: w_state_d = StStep;
            CmdDump: w_state_d = StCapture;
            default: w_state_d = StIdle;
          endcase
        end
      end
      StRun: begin
        if (w_cmd_fire && (io_bus.cmd_data == CmdHalt)) begin
          w_state_d = StCapture;
        end
      end
      StStep:    w_state_d = StCapture;
      StCapture: w_state_d = StSend;
      StSend: begin
        if (w_tx_fire && w_last_byte) begin
          w_state_d = StIdle;
        end
      end
      default:   w_state_d = StIdle;
    endcase
  end

  // Snapshot word order matches the frame: pc, cycle count, regs, mem.
  always_comb begin
    for (int i = 0; i < FrameWords; i++) begin
      w_snap_in[i] = '0;
    end
    w_snap_in[0] = {{(DATA_W-PC_W){1'b0}}, i_pc};
    w_snap_in[1] = r_cycle_cnt;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_snap_in[HdrWords+i] = i_regs_flat[DATA_W*i +: DATA_W];
    end
    for (int i = 0; i < NUM_MEM; i++) begin
      w_snap_in[HdrWords+NUM_REGS+i] = i_mem_flat[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cycle_cnt <= CYCLE_CNT_RST;
      r_byte_idx  <= '0;
      for (int i = 0; i < FrameWords; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_pipe_en) begin
        r_cycle_cnt <= r_cycle_cnt + DATA_W'(1);
      end
      if (r_state == StCapture) begin
        r_byte_idx <= '0;
        for (int i = 0; i < FrameWords; i++) begin
          r_snap[i] <= w_snap_in[i];
        end
      end else if (w_tx_fire) begin
        r_byte_idx <= w_last_byte ? '0 : r_byte_idx + IdxW'(1);
      end
    end
  end

  frame_serializer #(
    .DATA_W (DATA_W)
  ) u_frame_serializer (
    .i_word     (r_snap[w_word_idx]),
    .i_byte_sel (r_byte_idx[1:0]),
    .i_valid    (w_sending),
    .i_ready    (io_bus.tx_ready),
    .o_data     (w_tx_data),
    .o_valid    (w_tx_valid),
    .o_fire     (w_tx_fire)
  );

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.tx_data   = w_tx_data;
  assign io_bus.tx_valid  = w_tx_valid;
  assign o_pipe_enable    = w_pipe_en;
  assign o_halted         = (r_state == StIdle);

endmodule

// File: tb/tb_debug_dump.sv
// Directed scoreboard bench for debug_dump; a second instance with a preloaded
// cycle counter runs in lockstep to exercise counter wrap.
module tb_debug_dump;
  import debug_pkg::*;

  localparam int NR  = 32;
  localparam int NM  = 10;
  localparam int PCW = 10;
  localparam int FW  = 2 + NR + NM;
  localparam int FB  = 4 * FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            pe_a, pe_b, halt_a, halt_b;
  logic [PCW-1:0]  pc;
  logic [NR*32-1:0] regs_flat;
  logic [NM*32-1:0] mem_flat;

  debug_dump_if bus_a ();
  debug_dump_if bus_b ();

  debug_dump #(
    .NUM_REGS (NR),
    .NUM_MEM  (NM),
    .PC_W     (PCW)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .io_bus        (bus_a),
    .o_pipe_enable (pe_a),
    .i_pc          (pc),
    .i_regs_flat   (regs_flat),
    .i_mem_flat    (mem_flat),
    .o_halted      (halt_a)
  );

  debug_dump #(
    .NUM_REGS      (NR),
    .NUM_MEM       (NM),
    .PC_W          (PCW),
    .CYCLE_CNT_RST (32'hFFFF_FFFE)
  ) dut_wrap (
    .i_clk         (clk),
    .i_reset       (rst),
    .io_bus        (bus_b),
    .o_pipe_enable (pe_b),
    .i_pc          (pc),
    .i_regs_flat   (regs_flat),
    .i_mem_flat    (mem_flat),
    .o_halted      (halt_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb_a[$];
  logic [7:0]  sb_b[$];
  logic [31:0] regs_m [NR];
  logic [31:0] mem_m  [NM];
  logic [31:0] model_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NR; i++) regs_flat[32*i +: 32] = regs_m[i];
    for (int i = 0; i < NM; i++) mem_flat[32*i +: 32] = mem_m[i];
  endtask

  task automatic set_ready(input logic r);
    bus_a.tx_ready = r;
    bus_b.tx_ready = r;
  endtask

  task automatic set_cmd(input logic v, input logic [7:0] b);
    bus_a.cmd_valid = v;
    bus_a.cmd_data  = b;
    bus_b.cmd_valid = v;
    bus_b.cmd_data  = b;
  endtask

  // Wrap instance starts counting at 0xFFFFFFFE, so its field is offset by -2.
  task automatic push_frame(input logic [31:0] cnt);
    logic [31:0] wa, wb;
    for (int i = 0; i < FW; i++) begin
      if (i == 0)           wa = 32'(pc);
      else if (i == 1)      wa = cnt;
      else if (i < 2 + NR)  wa = regs_m[i-2];
      else                  wa = mem_m[i-2-NR];
      wb = (i == 1) ? cnt + 32'hFFFF_FFFE : wa;
      for (int b = 3; b >= 0; b--) begin
        sb_a.push_back(wa[8*b +: 8]);
        sb_b.push_back(wb[8*b +: 8]);
      end
    end
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic exp_ready);
    @(negedge clk);
    set_cmd(1'b1, b);
    chk("cmd_ready_a", 32'(bus_a.cmd_ready), 32'(exp_ready));
    chk("cmd_ready_b", 32'(bus_b.cmd_ready), 32'(exp_ready));
    @(negedge clk);
    set_cmd(1'b0, 8'h00);
  endtask

  task automatic recv_frame(input bit toggle, input int stop_at, input bit scramble,
                            input bit poke);
    int         got  = 0;
    int         iter = 0;
    logic       rdy  = 1'b0;
    bit         have_held = 1'b0;
    logic [7:0] held_a, ea, eb;
    while (got < FB && iter < 4 * FB && !(stop_at >= 0 && got == stop_at)) begin
      @(negedge clk);
      iter++;
      if (iter == 1) chk("first_byte_latency", 32'(bus_a.tx_valid), 32'd1);
      if (have_held) begin
        chk("hold_data", 32'(bus_a.tx_data), 32'(held_a));
        chk("hold_valid", 32'(bus_a.tx_valid), 32'd1);
        have_held = 1'b0;
      end
      if (!toggle && got > 0) chk("no_bubble", 32'(bus_a.tx_valid), 32'd1);
      if (scramble && got == 10) begin
        regs_flat = ~regs_flat;
        mem_flat  = ~mem_flat;
      end
      if (poke) begin
        if (got >= 3 && got < 8) begin
          set_cmd(1'b1, CmdStep);
          chk("cmd_ready_in_send", 32'(bus_a.cmd_ready), 32'd0);
        end else begin
          set_cmd(1'b0, 8'h00);
        end
      end
      rdy = toggle ? ~rdy : 1'b1;
      set_ready(rdy);
      if (bus_a.tx_valid) begin
        if (rdy) begin
          ea = (sb_a.size() > 0) ? sb_a.pop_front() : 8'hxx;
          eb = (sb_b.size() > 0) ? sb_b.pop_front() : 8'hxx;
          chk($sformatf("byte%0d_a", got), 32'(bus_a.tx_data), 32'(ea));
          chk($sformatf("byte%0d_b", got), 32'(bus_b.tx_data), 32'(eb));
          chk("valid_b", 32'(bus_b.tx_valid), 32'd1);
          got++;
        end else begin
          held_a    = bus_a.tx_data;
          have_held = 1'b1;
        end
      end
    end
    if (stop_at < 0) chk("frame_len", 32'(got), 32'(FB));
    else             chk("partial_len", 32'(got), 32'(stop_at));
    set_ready(1'b1);
  endtask

  task automatic end_frame();
    @(negedge clk);
    chk("post_frame_tx_valid_a", 32'(bus_a.tx_valid), 32'd0);
    chk("post_frame_tx_valid_b", 32'(bus_b.tx_valid), 32'd0);
    chk("post_frame_halted", 32'(halt_a), 32'd1);
    chk("sb_drained", 32'(sb_a.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cmd(1'b0, 8'h00);
    set_ready(1'b0);
    pc = 10'h2A5;
    for (int i = 0; i < NR; i++) regs_m[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    regs_m[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < NM; i++) mem_m[i] = 32'hA000_0000 + 32'(i) * 32'h0003_0007;
    apply_inputs();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_halted", 32'(halt_a), 32'd1);
    chk("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    chk("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus_a.tx_data), 32'h00);
    chk("rst_pipe_enable", 32'(pe_a), 32'd0);
    rst = 1'b0;
    model_cnt = 0;
    set_ready(1'b1);

    // Three single steps: counts 1,2,3 and, on the wrap instance, FFFFFFFF,0,1.
    for (int k = 0; k < 3; k++) begin
      model_cnt++;
      push_frame(model_cnt);
      send_cmd(CmdStep, 1'b1);
      chk("step_pe_on_a", 32'(pe_a), 32'd1);
      chk("step_pe_on_b", 32'(pe_b), 32'd1);
      @(negedge clk);
      chk("step_pe_off", 32'(pe_a), 32'd0);
      chk("capture_no_tx", 32'(bus_a.tx_valid), 32'd0);
      recv_frame(1'b0, -1, 1'b0, 1'b0);
      end_frame();
    end

    // Dump with ready toggling and inputs changing mid-frame.
    push_frame(model_cnt);
    send_cmd(CmdDump, 1'b1);
    chk("dump_pe_off", 32'(pe_a), 32'd0);
    recv_frame(1'b1, -1, 1'b1, 1'b0);
    end_frame();
    apply_inputs();

    // Reset at byte 50 with a simultaneous command and handshake.
    push_frame(model_cnt);
    send_cmd(CmdDump, 1'b1);
    recv_frame(1'b0, 50, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    set_cmd(1'b1, CmdRun);
    @(negedge clk);
    chk("abort_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    chk("abort_halted", 32'(halt_a), 32'd1);
    chk("abort_pe", 32'(pe_a), 32'd0);
    chk("abort_tx_data", 32'(bus_a.tx_data), 32'h00);
    rst = 1'b0;
    set_cmd(1'b0, 8'h00);
    sb_a.delete();
    sb_b.delete();
    model_cnt = 0;
    push_frame(model_cnt);
    send_cmd(CmdDump, 1'b1);
    recv_frame(1'b0, -1, 1'b0, 1'b0);
    end_frame();

    // Unknown byte in IDLE, run with an ignored step, halt after 101 enabled cycles.
    send_cmd(8'h41, 1'b1);
    chk("ignore_halted", 32'(halt_a), 32'd1);
    chk("ignore_pe", 32'(pe_a), 32'd0);
    send_cmd(CmdRun, 1'b1);
    chk("run_pe", 32'(pe_a), 32'd1);
    chk("run_not_halted", 32'(halt_a), 32'd0);
    send_cmd(CmdStep, 1'b1);
    chk("run_ignores_step_pe", 32'(pe_a), 32'd1);
    chk("run_ignores_step_tx", 32'(bus_a.tx_valid), 32'd0);
    repeat (97) @(negedge clk);
    model_cnt = 32'd101;
    push_frame(model_cnt);
    send_cmd(CmdHalt, 1'b1);
    chk("halt_pe_off", 32'(pe_a), 32'd0);
    recv_frame(1'b0, -1, 1'b0, 1'b0);
    end_frame();

    // Step offered during SEND must be refused.
    push_frame(model_cnt);
    send_cmd(CmdDump, 1'b1);
    recv_frame(1'b0, -1, 1'b0, 1'b1);
    end_frame();
    chk("poke_no_step_pe", 32'(pe_a), 32'd0);

    send_cmd(CmdHalt, 1'b1);
    chk("idle_halt_halted", 32'(halt_a), 32'd1);
    chk("idle_halt_pe", 32'(pe_a), 32'd0);
    chk("idle_halt_tx", 32'(bus_a.tx_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
